// File: rtl/systolic_seq_if.sv
// Operand, edge, array and result signals of systolic_seq.
// Modport slave is the sequencer's view; master is the surrounding environment.
interface systolic_seq_if #(
   parameter int unsigned width_p   = 32,
   parameter int unsigned rows_p    = 4,
   parameter int unsigned cols_p    = 4,
   parameter int unsigned k_width_p = 16
);
   logic                                     cmd_valid_i;
   logic                                     cmd_ready_o;
   logic [k_width_p-1:0]                     cmd_k_i;
   logic                                     src_valid_i;
   logic [rows_p*width_p-1:0]                src_a_i;
   logic [cols_p*width_p-1:0]                src_b_i;
   logic                                     src_yumi_o;
   logic                                     edge_valid_o;
   logic                                     edge_ready_i;
   logic [rows_p*width_p-1:0]                edge_a_o;
   logic [cols_p*width_p-1:0]                edge_b_o;
   logic                                     corner_done_i;
   logic [rows_p*cols_p*width_p-1:0]         accum_i;
   logic                                     arr_en_o;
   logic                                     arr_clear_o;
   logic                                     result_valid_o;
   logic                                     result_yumi_i;
   logic [width_p-1:0]                       result_o;
   logic [$clog2(rows_p*cols_p)-1:0]         result_idx_o;
   logic                                     busy_o;

   modport slave (
      input  cmd_valid_i, cmd_k_i, src_valid_i, src_a_i, src_b_i, edge_ready_i,
             corner_done_i, accum_i, result_yumi_i,
      output cmd_ready_o, src_yumi_o, edge_valid_o, edge_a_o, edge_b_o,
             arr_en_o, arr_clear_o, result_valid_o, result_o, result_idx_o, busy_o
   );

   modport master (
      output cmd_valid_i, cmd_k_i, src_valid_i, src_a_i, src_b_i, edge_ready_i,
             corner_done_i, accum_i, result_yumi_i,
      input  cmd_ready_o, src_yumi_o, edge_valid_o, edge_a_o, edge_b_o,
             arr_en_o, arr_clear_o, result_valid_o, result_o, result_idx_o, busy_o
   );
endinterface

// File: rtl/systolic_seq.sv
// Sequencer for a systolic MAC array: feeds K operand beats to the array edge,
// waits for the corner PE to finish K MACs, drains accumulators row-major,
// then clears the array for one cycle.
module systolic_seq #(
   parameter int unsigned width_p   = 32,
   parameter int unsigned rows_p    = 4,
   parameter int unsigned cols_p    = 4,
   parameter int unsigned k_width_p = 16
) (
   input  logic          clk_i,
   input  logic          reset_i,
   systolic_seq_if.slave bus
);
   localparam int unsigned words_lp = rows_p * cols_p;
   localparam int unsigned idx_w_lp = $clog2(words_lp);

   typedef enum logic [2:0] {IDLE, FEED, WAIT, DRAIN, CLEAR} state_e;

   state_e               state_r, state_n;
   logic [k_width_p-1:0] k_r, k_n;
   logic [k_width_p-1:0] feed_cnt_r, feed_cnt_n;
   logic [k_width_p-1:0] done_cnt_r, done_cnt_n;
   logic [idx_w_lp-1:0]  drain_idx_r, drain_idx_n;
   logic                 yumi;

   // State and counter registers; reset aborts any command in flight.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r     <= IDLE;
         k_r         <= '0;
         feed_cnt_r  <= '0;
         done_cnt_r  <= '0;
         drain_idx_r <= '0;
      end else begin
         state_r     <= state_n;
         k_r         <= k_n;
         feed_cnt_r  <= feed_cnt_n;
         done_cnt_r  <= done_cnt_n;
         drain_idx_r <= drain_idx_n;
      end
   end

   // Next-state, counter updates and all outputs.
   always_comb begin
      state_n     = state_r;
      k_n         = k_r;
      feed_cnt_n  = feed_cnt_r;
      done_cnt_n  = done_cnt_r;
      drain_idx_n = drain_idx_r;
      yumi        = 1'b0;

      bus.cmd_ready_o    = (state_r == IDLE);
      bus.edge_valid_o   = 1'b0;
      bus.src_yumi_o     = 1'b0;
      bus.edge_a_o       = bus.src_a_i;
      bus.edge_b_o       = bus.src_b_i;
      bus.arr_en_o       = 1'b0;
      bus.arr_clear_o    = reset_i | (state_r == CLEAR);
      bus.result_valid_o = 1'b0;
      bus.result_o       = bus.accum_i[int'(drain_idx_r) * width_p +: width_p];
      bus.result_idx_o   = drain_idx_r;
      bus.busy_o         = !reset_i && (state_r != IDLE);

      case (state_r)
         IDLE: begin
            if (bus.cmd_valid_i) begin
               k_n         = bus.cmd_k_i;
               feed_cnt_n  = '0;
               done_cnt_n  = '0;
               drain_idx_n = '0;
               state_n     = (bus.cmd_k_i != '0) ? FEED : DRAIN;
            end
         end
         FEED: begin
            yumi             = !reset_i && bus.src_valid_i && bus.edge_ready_i;
            bus.edge_valid_o = !reset_i && bus.src_valid_i;
            bus.src_yumi_o   = yumi;
            bus.arr_en_o     = !reset_i;
            if (yumi)
               feed_cnt_n = feed_cnt_r + k_width_p'(1);
            if (bus.corner_done_i && (done_cnt_r != k_r))
               done_cnt_n = done_cnt_r + k_width_p'(1);
            // Compare the post-increment counts so the last beat and a
            // coincident last corner pulse both resolve in this cycle.
            if (feed_cnt_n == k_r)
               state_n = (done_cnt_n == k_r) ? DRAIN : WAIT;
         end
         WAIT: begin
            bus.arr_en_o = !reset_i;
            if (bus.corner_done_i && (done_cnt_r != k_r))
               done_cnt_n = done_cnt_r + k_width_p'(1);
            if (done_cnt_n == k_r)
               state_n = DRAIN;
         end
         DRAIN: begin
            bus.result_valid_o = !reset_i;
            if (bus.result_yumi_i) begin
               if (drain_idx_r == idx_w_lp'(words_lp - 1))
                  state_n = CLEAR;
               else
                  drain_idx_n = drain_idx_r + idx_w_lp'(1);
            end
         end
         CLEAR: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_systolic_seq.sv
// Directed bench for systolic_seq on a 2x2 array with hand-set accumulator words.
module tb_systolic_seq;
   localparam int unsigned width_p   = 32;
   localparam int unsigned rows_p    = 2;
   localparam int unsigned cols_p    = 2;
   localparam int unsigned k_width_p = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   yumis;
   logic [31:0] acc_w [4];

   always #5 clk = ~clk;

   systolic_seq_if #(
      .width_p(width_p), .rows_p(rows_p), .cols_p(cols_p), .k_width_p(k_width_p)
   ) bus ();

   systolic_seq #(
      .width_p(width_p), .rows_p(rows_p), .cols_p(cols_p), .k_width_p(k_width_p)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic load_accum(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
      acc_w[0] = w0; acc_w[1] = w1; acc_w[2] = w2; acc_w[3] = w3;
      bus.accum_i = {w3, w2, w1, w0};
   endtask

   task automatic issue_cmd(input logic [15:0] k);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_k_i     = k;
      settle();
      check("cmd_ready", bus.cmd_ready_o, 1);
      tick();
      bus.cmd_valid_i = 1'b0;
   endtask

   task automatic drain_rest(input int first);
      for (int i = first; i < 4; i++) begin
         bus.result_yumi_i = 1'b1;
         settle();
         check("drain_valid", bus.result_valid_o, 1);
         check("drain_idx", bus.result_idx_o, i);
         check("drain_word", bus.result_o, acc_w[i]);
         check("drain_arr_en", bus.arr_en_o, 0);
         check("drain_src_yumi", bus.src_yumi_o, 0);
         tick();
      end
      bus.result_yumi_i = 1'b0;
      settle();
      check("clear_pulse", bus.arr_clear_o, 1);
      check("clear_no_result", bus.result_valid_o, 0);
      check("clear_busy", bus.busy_o, 1);
      tick();
      settle();
      check("idle_ready", bus.cmd_ready_o, 1);
      check("idle_no_clear", bus.arr_clear_o, 0);
      check("idle_busy", bus.busy_o, 0);
   endtask

   initial begin
      bus.cmd_valid_i   = 1'b0;
      bus.cmd_k_i       = '0;
      bus.src_valid_i   = 1'b0;
      bus.src_a_i       = 64'h1111_2222_3333_4444;
      bus.src_b_i       = 64'h5555_6666_7777_8888;
      bus.edge_ready_i  = 1'b0;
      bus.corner_done_i = 1'b0;
      bus.result_yumi_i = 1'b0;
      load_accum(32'hAAAA_0000, 32'hBBBB_0001, 32'hCCCC_0002, 32'hDDDD_0003);

      // reset values
      tick(); tick();
      bus.src_valid_i = 1'b1;
      settle();
      check("rst_src_yumi", bus.src_yumi_o, 0);
      check("rst_edge_valid", bus.edge_valid_o, 0);
      check("rst_arr_en", bus.arr_en_o, 0);
      check("rst_arr_clear", bus.arr_clear_o, 1);
      check("rst_result_valid", bus.result_valid_o, 0);
      check("rst_busy", bus.busy_o, 0);
      check("rst_cmd_ready", bus.cmd_ready_o, 1);
      reset = 1'b0;
      settle();
      check("post_rst_clear", bus.arr_clear_o, 0);

      // K=3, three feed beats, then WAIT until three corner pulses
      bus.edge_ready_i = 1'b1;
      yumis = 0;
      issue_cmd(16'd3);
      for (int i = 0; i < 3; i++) begin
         settle();
         check("k3_edge_valid", bus.edge_valid_o, 1);
         check("k3_src_yumi", bus.src_yumi_o, 1);
         check("k3_arr_en", bus.arr_en_o, 1);
         check("k3_edge_a", bus.edge_a_o, 64'h1111_2222_3333_4444);
         check("k3_edge_b", bus.edge_b_o, 64'h5555_6666_7777_8888);
         yumis += int'(bus.src_yumi_o);
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         bus.corner_done_i = 1'b1;
         settle();
         check("k3_wait_no_yumi", bus.src_yumi_o, 0);
         check("k3_wait_edge_valid", bus.edge_valid_o, 0);
         check("k3_wait_arr_en", bus.arr_en_o, 1);
         check("k3_wait_no_result", bus.result_valid_o, 0);
         yumis += int'(bus.src_yumi_o);
         tick();
      end
      bus.corner_done_i = 1'b0;
      check("k3_total_yumis", yumis, 3);
      drain_rest(0);

      // K=0 goes straight to DRAIN
      load_accum(32'h0000_0000, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000);
      issue_cmd(16'd0);
      drain_rest(0);

      // stray result yumi in IDLE is ignored
      bus.result_yumi_i = 1'b1;
      settle();
      check("idle_result_valid", bus.result_valid_o, 0);
      tick();
      bus.result_yumi_i = 1'b0;

      // K=2 with edge_ready toggling 1,0,1,0
      load_accum(32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 32'h0000_0040);
      issue_cmd(16'd2);
      bus.edge_ready_i = 1'b1; settle();
      check("tog_yumi_0", bus.src_yumi_o, 1);
      tick();
      bus.edge_ready_i = 1'b0; settle();
      check("tog_yumi_1", bus.src_yumi_o, 0);
      check("tog_edge_valid_1", bus.edge_valid_o, 1);
      tick();
      bus.edge_ready_i = 1'b1; settle();
      check("tog_yumi_2", bus.src_yumi_o, 1);
      tick();
      bus.edge_ready_i = 1'b0; settle();
      check("tog_wait_yumi", bus.src_yumi_o, 0);
      check("tog_wait_edge_valid", bus.edge_valid_o, 0);
      check("tog_wait_arr_en", bus.arr_en_o, 1);
      for (int i = 0; i < 2; i++) begin
         bus.corner_done_i = 1'b1;
         settle();
         check("tog_wait_no_result", bus.result_valid_o, 0);
         tick();
      end
      bus.corner_done_i = 1'b0;

      // consume idx 0, then hold idx 1 for five cycles
      bus.result_yumi_i = 1'b1; settle();
      check("hold_first_idx", bus.result_idx_o, 0);
      tick();
      bus.result_yumi_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         settle();
         check("hold_valid", bus.result_valid_o, 1);
         check("hold_idx", bus.result_idx_o, 1);
         check("hold_word", bus.result_o, 32'h0000_0020);
         check("hold_arr_en", bus.arr_en_o, 0);
         tick();
      end
      drain_rest(1);

      // K=1, last corner pulse coincides with the last feed beat
      bus.edge_ready_i = 1'b1;
      issue_cmd(16'd1);
      bus.corner_done_i = 1'b1;
      settle();
      check("k1_yumi", bus.src_yumi_o, 1);
      tick();
      bus.corner_done_i = 1'b0;
      settle();
      check("k1_drain_next", bus.result_valid_o, 1);
      drain_rest(0);

      // stray corner pulses in IDLE must not count toward the next command
      bus.corner_done_i = 1'b1;
      tick();
      issue_cmd(16'd1);
      bus.corner_done_i = 1'b0;
      settle();
      check("stray_feed_yumi", bus.src_yumi_o, 1);
      tick();
      settle();
      check("stray_ignored", bus.result_valid_o, 0);
      check("stray_wait_arr_en", bus.arr_en_o, 1);
      bus.corner_done_i = 1'b1;
      tick();
      bus.corner_done_i = 1'b0;
      drain_rest(0);

      // reset mid-DRAIN at idx 2
      issue_cmd(16'd0);
      bus.result_yumi_i = 1'b1;
      tick(); tick();
      bus.result_yumi_i = 1'b0;
      settle();
      check("mid_drain_idx", bus.result_idx_o, 2);
      reset = 1'b1;
      settle();
      check("mid_drain_rst_valid", bus.result_valid_o, 0);
      check("mid_drain_rst_clear", bus.arr_clear_o, 1);
      tick();
      reset = 1'b0;
      settle();
      check("after_rst_ready", bus.cmd_ready_o, 1);
      check("after_rst_valid", bus.result_valid_o, 0);
      check("after_rst_busy", bus.busy_o, 0);
      issue_cmd(16'd0);
      drain_rest(0);

      // reset mid-FEED aborts without results
      issue_cmd(16'd3);
      tick();
      reset = 1'b1;
      settle();
      check("feed_rst_yumi", bus.src_yumi_o, 0);
      check("feed_rst_arr_en", bus.arr_en_o, 0);
      tick();
      reset = 1'b0;
      bus.corner_done_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         check("feed_rst_no_result", bus.result_valid_o, 0);
         check("feed_rst_idle", bus.busy_o, 0);
         tick();
      end
      bus.corner_done_i = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
